// File: rtl/seg_scan_decoder_if.sv
// Bus between a multiplexed 7-segment display driver (master side) and the
// read-back decoder (slave side): scan lines in, decoded frame out.
interface seg_scan_decoder_if;
    logic [7:0]  an;
    logic [7:0]  seg_in;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  bad;
    logic        digit_vld;
    logic [2:0]  digit_idx;
    logic        frame_done;
    logic        multi_err;

    modport master (
        output an, seg_in,
        input  digits, dp, blank, bad, digit_vld, digit_idx, frame_done, multi_err
    );

    modport slave (
        input  an, seg_in,
        output digits, dp, blank, bad, digit_vld, digit_idx, frame_done, multi_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Read-back decoder for the 8-digit multiplexed 7-segment bus: rebuilds digit,
// dp and blank/bad status per anode slot. Macro SEG_DECODE_HEX_EN adds A-F decode.
module seg_scan_decoder #(
    parameter int SETTLE_CYC = 16,
    parameter int MIN_SLOT   = 1024,
    parameter int CNT_W      = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_decoder_if.slave   bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_ACCUM, ST_COMMIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] MIN_LIM    = CNT_W'(MIN_SLOT);

    function automatic logic an_onehot(input logic [7:0] an);
        logic [7:0] lit;
        lit = ~an;
        return (lit != 8'h00) && ((lit & (lit - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] an_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!an[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Result is {bad, blank, digit}; segments are active-low gfedcba.
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        logic [5:0] res;
        case (s)
            7'b1000000: res = {2'b00, 4'h0};
            7'b1111001: res = {2'b00, 4'h1};
            7'b0100100: res = {2'b00, 4'h2};
            7'b0110000: res = {2'b00, 4'h3};
            7'b0011001: res = {2'b00, 4'h4};
            7'b0010010: res = {2'b00, 4'h5};
            7'b0000010: res = {2'b00, 4'h6};
            7'b1111000: res = {2'b00, 4'h7};
            7'b0000000: res = {2'b00, 4'h8};
            7'b0010000: res = {2'b00, 4'h9};
            7'b1111111: res = {2'b01, 4'h0};
`ifdef SEG_DECODE_HEX_EN
            7'b0001000: res = {2'b00, 4'hA};
            7'b0000011: res = {2'b00, 4'hB};
            7'b1000110: res = {2'b00, 4'hC};
            7'b0100001: res = {2'b00, 4'hD};
            7'b0000110: res = {2'b00, 4'hE};
            7'b0001110: res = {2'b00, 4'hF};
`endif
            default:    res = {2'b10, 4'hF};
        endcase
        return res;
    endfunction

    function automatic state_t classify(input logic [7:0] an, input logic [CNT_W-1:0] cnt);
        state_t st;
        if (!an_onehot(an)) st = ST_IDLE;
        else if (cnt < SETTLE_LIM) st = ST_SETTLE;
        else st = ST_ACCUM;
        return st;
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       an_q, an_d, an_prev_q, an_prev_d, seg_q, seg_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [7:0]       acc_q, acc_d, seen_q, seen_d;
    logic [31:0]      digits_q, digits_d;
    logic [7:0]       dp_q, dp_d, blank_q, blank_d, bad_q, bad_d;
    logic             digit_vld_q, digit_vld_d, frame_done_q, frame_done_d;
    logic             multi_err_q, multi_err_d;
    logic [2:0]       digit_idx_q, digit_idx_d;

    logic             chg_s;
    logic [2:0]       k_s;
    logic [5:0]       dec_s;
    logic [7:0]       seen_nx_s;

    // State, input and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            an_q         <= 8'hFF;
            an_prev_q    <= 8'hFF;
            seg_q        <= 8'hFF;
            slot_cnt_q   <= '0;
            acc_q        <= 8'hFF;
            seen_q       <= 8'h00;
            digits_q     <= 32'h0000_0000;
            dp_q         <= 8'h00;
            blank_q      <= 8'hFF;
            bad_q        <= 8'h00;
            digit_vld_q  <= 1'b0;
            frame_done_q <= 1'b0;
            multi_err_q  <= 1'b0;
            digit_idx_q  <= 3'd0;
        end else begin
            state_q      <= state_d;
            an_q         <= an_d;
            an_prev_q    <= an_prev_d;
            seg_q        <= seg_d;
            slot_cnt_q   <= slot_cnt_d;
            acc_q        <= acc_d;
            seen_q       <= seen_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            bad_q        <= bad_d;
            digit_vld_q  <= digit_vld_d;
            frame_done_q <= frame_done_d;
            multi_err_q  <= multi_err_d;
            digit_idx_q  <= digit_idx_d;
        end
    end

    // Slot tracking, accumulation, commit decision and frame bookkeeping.
    always_comb begin
        an_d         = bus.an;
        seg_d        = bus.seg_in;
        an_prev_d    = an_q;
        state_d      = state_q;
        acc_d        = acc_q;
        seen_d       = seen_q;
        digits_d     = digits_q;
        dp_d         = dp_q;
        blank_d      = blank_q;
        bad_d        = bad_q;
        digit_vld_d  = 1'b0;
        frame_done_d = 1'b0;
        multi_err_d  = 1'b0;
        digit_idx_d  = digit_idx_q;

        chg_s     = (an_q != an_prev_q);
        k_s       = an_index(an_prev_q);
        dec_s     = seg_decode(acc_q[6:0]);
        seen_nx_s = seen_q | (8'h01 << k_s);

        if (chg_s) begin
            slot_cnt_d = '0;
        end else if (slot_cnt_q == CNT_MAX) begin
            slot_cnt_d = slot_cnt_q;
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end

        if (chg_s) begin
            // acc and slot_cnt still describe the old slot during the change cycle.
            acc_d       = 8'hFF;
            multi_err_d = !an_onehot(an_q) && (an_q != 8'hFF);
            if ((state_q == ST_ACCUM) && (slot_cnt_q >= MIN_LIM)) begin
                state_d                   = ST_COMMIT;
                digits_d[{k_s, 2'b00} +: 4] = dec_s[3:0];
                dp_d[k_s]                 = ~acc_q[7];
                blank_d[k_s]              = dec_s[4];
                bad_d[k_s]                = dec_s[5];
                digit_vld_d               = 1'b1;
                digit_idx_d               = k_s;
                if (seen_nx_s == 8'hFF) begin
                    frame_done_d = 1'b1;
                    seen_d       = 8'h00;
                end else begin
                    seen_d       = seen_nx_s;
                end
            end else begin
                state_d = classify(an_q, slot_cnt_d);
            end
        end else begin
            if (state_q == ST_ACCUM) begin
                acc_d = acc_q & seg_q;
            end else begin
                acc_d = acc_q;
            end
            state_d = classify(an_q, slot_cnt_d);
        end
    end

    assign bus.digits     = digits_q;
    assign bus.dp         = dp_q;
    assign bus.blank      = blank_q;
    assign bus.bad        = bad_q;
    assign bus.digit_vld  = digit_vld_q;
    assign bus.digit_idx  = digit_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.multi_err  = multi_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: each committed slot's expected
// result is queued when the next slot is driven and popped on digit_vld.
module tb_seg_scan_decoder;

    localparam int MIN_SLOT = 1024;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] dig;
        logic       dp;
        logic       blank;
        logic       bad;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_decoder_if bus_if();

    seg_scan_decoder #(
        .SETTLE_CYC (16),
        .MIN_SLOT   (MIN_SLOT),
        .CNT_W      (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          multi_cnt = 0;
    logic [7:0]  seen_m = 8'h00;
    logic [31:0] digits_m = 32'h0;
    bit          pend_v = 1'b0;
    exp_t        pend;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic push_exp(input exp_t e_in);
        exp_t e;
        logic [7:0] nx;
        e  = e_in;
        nx = seen_m | (8'h01 << e.idx);
        e.fd = (nx == 8'hFF);
        seen_m = e.fd ? 8'h00 : nx;
        digits_m[e.idx*4 +: 4] = e.dig;
        sb_q.push_back(e);
    endtask

    // Drive one slot; the previous slot's expectation is queued as this one starts.
    task automatic drive_slot(input logic [7:0] an_v, input logic [7:0] seg_v,
                              input int len, input bit pwm);
        exp_t e;
        if (pend_v) push_exp(pend);
        pend_v = ($countones(~an_v) == 1) && (len >= MIN_SLOT + 2);
        if (pend_v) begin
            e = '0;
            for (int i = 0; i < 8; i++) if (!an_v[i] && e.idx == 3'd0 && i != 0) e.idx = 3'(i);
            e.dp = ~seg_v[7];
            if (seg_v[6:0] == 7'h7F) begin
                e.blank = 1'b1; e.dig = 4'h0;
            end else begin
                e.bad = 1'b1; e.dig = 4'hF;
                for (int d = 0; d < 10; d++) if (enc(d) == seg_v[6:0]) begin e.bad = 1'b0; e.dig = 4'(d); end
`ifdef SEG_DECODE_HEX_EN
                if (seg_v[6:0] == 7'b0001000) begin e.bad = 1'b0; e.dig = 4'hA; end
`endif
            end
            pend = e;
        end
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            bus_if.an     = an_v;
            bus_if.seg_in = (pwm && (c % 16 != 0)) ? 8'hFF : seg_v;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sb_q.delete();
        pend_v   = 1'b0;
        seen_m   = 8'h00;
        digits_m = 32'h0;
        check_val("rst_digits", bus_if.digits, 32'h0);
        check_val("rst_dp", 32'(bus_if.dp), 32'h00);
        check_val("rst_blank", 32'(bus_if.blank), 32'hFF);
        check_val("rst_bad", 32'(bus_if.bad), 32'h00);
        check_val("rst_vld", 32'(bus_if.digit_vld), 32'h0);
        check_val("rst_idx", 32'(bus_if.digit_idx), 32'h0);
        check_val("rst_fd", 32'(bus_if.frame_done), 32'h0);
        check_val("rst_multi", 32'(bus_if.multi_err), 32'h0);
        rst_n = 1'b1;
    endtask

    // Output monitor: pops the scoreboard on every committed digit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.multi_err) multi_cnt++;
            if (bus_if.frame_done) check_val("fd_with_vld", 32'(bus_if.digit_vld), 32'h1);
            if (bus_if.digit_vld && sb_q.size() == 0) begin
                check_val("vld_unexpected", 32'(bus_if.digit_vld), 32'h0);
            end else if (bus_if.digit_vld) begin
                automatic exp_t e = sb_q.pop_front();
                check_val("digit_idx", 32'(bus_if.digit_idx), 32'(e.idx));
                check_val("digit_val", 32'(bus_if.digits[e.idx*4 +: 4]), 32'(e.dig));
                check_val("dp_bit", 32'(bus_if.dp[e.idx]), 32'(e.dp));
                check_val("blank_bit", 32'(bus_if.blank[e.idx]), 32'(e.blank));
                check_val("bad_bit", 32'(bus_if.bad[e.idx]), 32'(e.bad));
                check_val("frame_done", 32'(bus_if.frame_done), 32'(e.fd));
            end
        end
    end

    initial begin
        int m0;
        rst_n         = 1'b0;
        bus_if.an     = 8'hFF;
        bus_if.seg_in = 8'hFF;
        do_reset();

        // Basic frame: slot k shows k+1, dp lit on slot 2.
        for (int k = 0; k < 8; k++)
            drive_slot(~(8'h01 << k), {(k != 2), enc(k + 1)}, 2000, 1'b0);
        // Same frame with the pattern present 1 cycle in 16.
        for (int k = 0; k < 8; k++)
            drive_slot(~(8'h01 << k), {(k != 2), enc(k + 1)}, 1200, 1'b1);
        // Short slot on anode 3 showing 7 must be dropped.
        drive_slot(~8'h08, {1'b1, enc(7)}, 500, 1'b0);
        drive_slot(8'hFF, 8'hFF, 100, 1'b0);
        check_val("frame_digits", bus_if.digits, 32'h8765_4321);
        check_val("pwm_blank", 32'(bus_if.blank), 32'h00);
        check_val("pwm_dp", 32'(bus_if.dp), 32'h04);
        check_val("short_keep3", 32'(bus_if.digits[15:12]), 32'h4);

        // Two anodes low at once.
        m0 = multi_cnt;
        drive_slot(8'b1111_1100, {1'b1, enc(1)}, 1500, 1'b0);
        drive_slot(8'hFF, 8'hFF, 100, 1'b0);
        check_val("multi_pulses", 32'(multi_cnt - m0), 32'd1);

        // Hex "A" pattern on slot 5, fully dark slot 6.
        drive_slot(~8'h20, 8'h88, 1200, 1'b0);
        drive_slot(~8'h40, 8'hFF, 1200, 1'b0);
        drive_slot(8'hFF, 8'hFF, 100, 1'b0);
`ifdef SEG_DECODE_HEX_EN
        check_val("hex_digit5", 32'(bus_if.digits[23:20]), 32'hA);
        check_val("hex_bad5", 32'(bus_if.bad[5]), 32'h0);
`else
        check_val("hex_digit5", 32'(bus_if.digits[23:20]), 32'hF);
        check_val("hex_bad5", 32'(bus_if.bad[5]), 32'h1);
`endif
        check_val("blank6", 32'(bus_if.blank[6]), 32'h1);

        // Reset after four commits, in the middle of slot 4.
        for (int k = 0; k < 4; k++)
            drive_slot(~(8'h01 << k), {1'b1, enc((k + 5) % 10)}, 1200, 1'b0);
        drive_slot(~8'h10, {1'b1, enc(9)}, 600, 1'b0);
        do_reset();
        for (int k = 0; k < 8; k++)
            drive_slot(~(8'h01 << k), {1'b1, enc((k * 3) % 10)}, 1200, 1'b0);
        drive_slot(8'hFF, 8'hFF, 100, 1'b0);
        check_val("post_rst_digits", bus_if.digits, digits_m);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
